// File: rtl/seq_check2b.sv
// seq_check2b: locks onto a free-running 2-bit counter observed on din and flags breaks.
// Optional macro SEQ_CHECK_DOWN_EN adds a dir input selecting down-counting checks.
module seq_check2b #(
  parameter int LOCK_LEN = 2,
  parameter int ERRW     = 4
) (
  input  logic            clk,
  input  logic            hr,
  input  logic            en,
  input  logic [1:0]      din,
`ifdef SEQ_CHECK_DOWN_EN
  input  logic            dir,
`endif
  output logic            locked,
  output logic            err,
  output logic [ERRW-1:0] err_cnt,
  output logic [1:0]      last
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // good counts transitions already seen, so good == LOCK_LEN-1 means this one locks
  localparam logic [2:0]      LOCK_M1 = 3'(LOCK_LEN - 1);
  localparam logic [ERRW-1:0] CNT_MAX = {ERRW{1'b1}};

  state_t            state_q, state_d;
  logic [2:0]        good_q, good_d;
  logic [1:0]        last_q, last_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [ERRW-1:0]   err_cnt_q, err_cnt_d;
  logic [1:0]        exp_s;

  // expected next sample from the last consumed one
  always_comb begin
`ifdef SEQ_CHECK_DOWN_EN
    if (dir) begin
      exp_s = last_q - 2'd1;
    end else begin
      exp_s = last_q + 2'd1;
    end
`else
    exp_s = last_q + 2'd1;
`endif
  end

  // next-state and output logic
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    last_d    = last_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (en) begin
      last_d = din;
      case (state_q)
        IDLE: begin
          good_d   = 3'd0;
          locked_d = 1'b0;
          state_d  = TRACK;
        end
        TRACK: begin
          if (din == exp_s) begin
            good_d = good_q + 3'd1;
            if (good_q == LOCK_M1) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d  = TRACK;
            end
          end else begin
            good_d = 3'd0;
          end
        end
        LOCKED: begin
          if (din != exp_s) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            good_d   = 3'd0;
            state_d  = TRACK;
            if (err_cnt_q != CNT_MAX) begin
              err_cnt_d = err_cnt_q + {{(ERRW-1){1'b0}}, 1'b1};
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d  = IDLE;
          good_d   = 3'd0;
          locked_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (hr) begin
      state_q   <= IDLE;
      good_q    <= 3'd0;
      last_q    <= 2'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= {ERRW{1'b0}};
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      last_q    <= last_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign last    = last_q;

endmodule

// File: tb/tb_seq_check2b.sv
// Bench for seq_check2b: reference model feeds a scoreboard queue, plus directed checks.
module tb_seq_check2b;
  localparam int LL = 2;
  localparam int EW = 2;

  typedef struct {
    logic          locked;
    logic          err;
    logic [EW-1:0] cnt;
    logic [1:0]    last;
  } exp_t;

  logic          clk = 1'b0;
  logic          hr = 1'b0, en = 1'b0, dir = 1'b0;
  logic [1:0]    din = 2'd0;
  logic          locked, err;
  logic [EW-1:0] err_cnt;
  logic [1:0]    last;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  int            m_state = 0;
  int            m_good = 0;
  logic [1:0]    m_last = 2'd0;
  logic          m_locked = 1'b0;
  logic [EW-1:0] m_cnt = '0;

  always #5 clk = ~clk;

  seq_check2b #(.LOCK_LEN(LL), .ERRW(EW)) dut (
    .clk(clk), .hr(hr), .en(en), .din(din),
`ifdef SEQ_CHECK_DOWN_EN
    .dir(dir),
`endif
    .locked(locked), .err(err), .err_cnt(err_cnt), .last(last)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // drive one edge, predict with the model, compare after the edge
  task automatic step(input logic h, input logic e, input logic [1:0] d);
    exp_t x;
    logic [1:0] ex;
    logic m_err;
    hr = h; en = e; din = d;
`ifdef SEQ_CHECK_DOWN_EN
    ex = dir ? (m_last - 2'd1) : (m_last + 2'd1);
`else
    ex = m_last + 2'd1;
`endif
    m_err = 1'b0;
    if (h) begin
      m_state = 0; m_good = 0; m_last = 2'd0; m_locked = 1'b0; m_cnt = '0;
    end else if (e) begin
      if (m_state == 0) begin
        m_state = 1; m_good = 0;
      end else if (m_state == 1) begin
        if (d == ex) begin
          m_good++;
          if (m_good == LL) begin m_state = 2; m_locked = 1'b1; end
        end else m_good = 0;
      end else if (d != ex) begin
        m_err = 1'b1; m_locked = 1'b0; m_state = 1; m_good = 0;
        if (m_cnt != {EW{1'b1}}) m_cnt++;
      end
      m_last = d;
    end
    x.locked = m_locked; x.err = m_err; x.cnt = m_cnt; x.last = m_last;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    chk("sb_locked", {7'd0, locked}, {7'd0, x.locked});
    chk("sb_err", {7'd0, err}, {7'd0, x.err});
    chk("sb_cnt", 8'(err_cnt), 8'(x.cnt));
    chk("sb_last", {6'd0, last}, {6'd0, x.last});
  endtask

  initial begin
    int sat_tbl[5];
    logic [1:0] lst;
    sat_tbl = '{1, 2, 3, 3, 3};

    // reset with en high and din=2
    step(1'b1, 1'b1, 2'd2);
    chk("rst_locked", {7'd0, locked}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    chk("rst_cnt", 8'(err_cnt), 8'd0);
    chk("rst_last", {6'd0, last}, 8'd0);

    // lock and wrap
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd1);
    chk("pre_lock", {7'd0, locked}, 8'd0);
    step(1'b0, 1'b1, 2'd2);
    chk("lock_rise", {7'd0, locked}, 8'd1);
    step(1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b1, 2'd0);
    chk("wrap_locked", {7'd0, locked}, 8'd1);
    chk("wrap_err", {7'd0, err}, 8'd0);
    step(1'b0, 1'b1, 2'd1);

    // break from last=1 with din=3, then relock
    step(1'b0, 1'b1, 2'd3);
    chk("brk_err", {7'd0, err}, 8'd1);
    chk("brk_cnt", 8'(err_cnt), 8'd1);
    chk("brk_locked", {7'd0, locked}, 8'd0);
    step(1'b0, 1'b1, 2'd0);
    chk("brk_err_pulse", {7'd0, err}, 8'd0);
    step(1'b0, 1'b1, 2'd1);
    chk("relock", {7'd0, locked}, 8'd1);

    // hold with en low
    step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd3);
    step(1'b0, 1'b0, 2'd2);
    chk("hold_last", {6'd0, last}, 8'd1);
    chk("hold_err", {7'd0, err}, 8'd0);
    step(1'b0, 1'b1, 2'd2);
    chk("hold_locked", {7'd0, locked}, 8'd1);

    // saturation of err_cnt
    step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd0);
    lst = 2'd0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, lst + 2'd1);
      step(1'b0, 1'b1, lst + 2'd2);
      chk("sat_locked", {7'd0, locked}, 8'd1);
      lst = lst + 2'd2;
      step(1'b0, 1'b1, lst);
      chk("sat_err", {7'd0, err}, 8'd1);
      chk("sat_cnt", 8'(err_cnt), 8'(sat_tbl[i]));
    end

    // reset while locked drops history
    step(1'b0, 1'b1, lst + 2'd1);
    step(1'b0, 1'b1, lst + 2'd2);
    step(1'b1, 1'b1, 2'd3);
    chk("mid_rst_locked", {7'd0, locked}, 8'd0);
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd1);
    chk("mid_rst_nolock", {7'd0, locked}, 8'd0);
    step(1'b0, 1'b1, 2'd2);
    chk("mid_rst_relock", {7'd0, locked}, 8'd1);

`ifdef SEQ_CHECK_DOWN_EN
    // down-counting lock, direction change, reset
    step(1'b1, 1'b0, 2'd0);
    dir = 1'b1;
    step(1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd1);
    step(1'b0, 1'b1, 2'd0);
    chk("down_lock", {7'd0, locked}, 8'd1);
    step(1'b0, 1'b1, 2'd3);
    chk("down_wrap", {7'd0, locked}, 8'd1);
    chk("down_wrap_err", {7'd0, err}, 8'd0);
    dir = 1'b0;
    step(1'b0, 1'b1, 2'd0);
    chk("dir_swap_locked", {7'd0, locked}, 8'd1);
    step(1'b1, 1'b0, 2'd0);
    chk("down_rst_locked", {7'd0, locked}, 8'd0);
    chk("down_rst_cnt", 8'(err_cnt), 8'd0);
    chk("down_rst_last", {6'd0, last}, 8'd0);
`endif

    // randomized traffic biased toward correct sequences
    for (int i = 0; i < 400; i++) begin
      logic [1:0] d;
`ifdef SEQ_CHECK_DOWN_EN
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      d = dir ? (m_last - 2'd1) : (m_last + 2'd1);
`else
      d = m_last + 2'd1;
`endif
      if ($urandom_range(0, 4) == 0) d = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_check2b.md
SEQ_CHECK2B -- requirements
Module: seq_check2b

Interface
REQ-001 The block SHALL have parameter LOCK_LEN, default 2, giving the consecutive correct transitions needed to lock (legal range 1..7).
REQ-002 The block SHALL have parameter ERRW, default 4, giving the width of the error counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port hr, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: sample enable; din is consumed only on edges where en=1.
REQ-006 The block SHALL have port din, input, 2 bits: the observed 2-bit counter/register value.
REQ-007 The block SHALL have port locked, output, 1 bit: high while the sequence is tracked as valid.
REQ-008 The block SHALL have port err, output, 1 bit: a one-cycle pulse on a sequence break while locked.
REQ-009 The block SHALL have port err_cnt, output, ERRW bits: the saturating count of err pulses.
REQ-010 The block SHALL have port last, output, 2 bits: the most recently consumed din.

Function
REQ-011 The block SHALL implement an FSM with states IDLE (no reference sample), TRACK (counting good transitions) and LOCKED.
REQ-012 The expected value SHALL be exp = (last + 1) mod 4, so 3 is followed by 0 with no error.
REQ-013 In IDLE with en=1, the block SHALL load last<=din, set good=0 and move to TRACK; locked and err stay 0.
REQ-014 In TRACK with en=1 and din==exp, the block SHALL increment good; when good+1 == LOCK_LEN it SHALL move to LOCKED with locked=1 from the same edge.
REQ-015 In TRACK with en=1 and din!=exp, the block SHALL set good=0, stay in TRACK and assert no err.
REQ-016 In LOCKED with en=1 and din==exp, the block SHALL stay in LOCKED.
REQ-017 In LOCKED with en=1 and din!=exp, the block SHALL set err=1 for exactly one cycle, increment err_cnt, clear locked and move to TRACK with good=0.
REQ-018 With en=1, last SHALL load din on every edge, in every state.
REQ-019 err_cnt SHALL saturate at 2^ERRW-1 and never wrap.
REQ-020 With en=0, the block SHALL hold state, last, locked, good and err_cnt, and err SHALL be 0.
REQ-021 All outputs SHALL be registered, with a latency of one edge from the sampled din to the updated outputs; there SHALL be no combinational path from din to any output.

Reset
REQ-022 hr=1 at a rising clk edge SHALL force IDLE, good=0, locked=0, err=0, err_cnt=0 and last=0, taking priority over en and din.
REQ-023 hr asserted mid-operation, including while LOCKED, SHALL discard all tracking history; relocking SHALL require a fresh sample plus LOCK_LEN good transitions.

Configuration
REQ-024 When macro SEQ_CHECK_DOWN_EN is defined, the block SHALL add port dir (input, 1 bit) and SHALL use exp = (last - 1) mod 4 when dir=1, so 0 is followed by 3 with no error, and (last + 1) mod 4 when dir=0.
REQ-025 A change of dir SHALL NOT itself clear locked; the next sample SHALL be checked against the newly selected direction.
REQ-026 When SEQ_CHECK_DOWN_EN is not defined, the dir port SHALL be absent and checking SHALL be up-only.

Verification
REQ-027 Reset: hold hr=1 for 1 cycle with en=1 and din=2 -> locked=0, err=0, err_cnt=0, last=0.
REQ-028 Lock and wrap: with LOCK_LEN=2, feed din 0,1,2,3,0,1 with en=1 -> locked rises after the edge sampling 2 and stays high through the 3->0 wrap; err stays 0.
REQ-029 Break: while locked with last=1, feed din=3 -> err=1 for one cycle, err_cnt 0->1, locked=0; then feeding 0,1 -> locked=1 again.
REQ-030 Hold: while locked, drive en=0 for 3 cycles with din=0,3,2 -> no output changes and err=0; en=1 with din=exp -> still locked.
REQ-031 Saturation: with ERRW=2, force 5 lock/break cycles -> err_cnt reads 1,2,3,3,3 and err still pulses each time.
REQ-032 Down and reset, with SEQ_CHECK_DOWN_EN defined and dir=1: feed 2,1,0,3 -> locked=1; then hr=1 for one cycle -> IDLE with all outputs 0.
